control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter DIV_TIMEOUT, default 40: maximum number of wait cycles for calc_finished; used only under CU_DIV_TIMEOUT_EN.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 clr  in  1  reset, asynchronous, active-low.
REQ-004 run_req  in  1  start/resume request, level-sensitive.
REQ-005 IR  in  32  instruction register contents; opcode is IR[31:27].
REQ-006 CON_output / calc_finished  in  1 each  branch condition / divider done.
REQ-007 PC_out, MAR_rd, IncPC, Read, MDR_rd, MDR_out, IR_rd, Y_rd, Zlo_rd, Zhi_rd, Zlo_out, Zhi_out, HI_rd, LO_rd, HI_out, LO_out, PC_rd, Write, CONin, Gra, Grb, Grc, Rin, R_out, BAout, C_out, In_out, Out_rd, reset_div  out  1 each  datapath strobes.
REQ-008 op_sel  out  5  ALU operation select.
REQ-009 running  out  1  high outside HALT; fault  out  1  divide-timeout flag.

Function
REQ-010 Moore FSM; every strobe is a registered decode of the state, valid for exactly the cycle the state is held.
REQ-011 States: HALT, T0, T1, T2, plus execute states T3..T7 and DIV_WAIT.
REQ-012 HALT -> T0 when run_req=1; all strobes 0 in HALT.
REQ-013 T0: PC_out, MAR_rd, IncPC. T1: Read, MDR_rd. T2: MDR_out, IR_rd. Fetch always takes 3 cycles.
REQ-014 T3 decodes IR[31:27] through the shared opcode table; unknown opcodes behave as nop.
REQ-015 Register ops (add, sub, and, or, shl, shr, rol, ror): T3 Grb+R_out+Y_rd; T4 Grc+R_out+op_sel+Zlo_rd; T5 Zlo_out+Gra+Rin; then T0.
REQ-016 Immediate ops (addi, andi, ori): as REQ-015, except T4 drives C_out in place of Grc+R_out.
REQ-017 ld/ldi: T3 Grb+BAout+Y_rd; T4 C_out+op_sel=ADD+Zlo_rd; T5 Zlo_out+MAR_rd (ld) or Zlo_out+Gra+Rin (ldi, ends); ld continues T6 Read+MDR_rd; T7 MDR_out+Gra+Rin.
REQ-018 st: T3–T5 as ld; T6 Gra+R_out+MDR_rd; T7 Write.
REQ-019 mul: T3 Gra+R_out+Y_rd; T4 Grb+R_out+op_sel=MUL+Zhi_rd+Zlo_rd; T5 Zlo_out+LO_rd; T6 Zhi_out+HI_rd.
REQ-020 div: T4 additionally pulses reset_div for one cycle, then DIV_WAIT holds op_sel=DIV with Grb+R_out until calc_finished=1, then Zhi_rd+Zlo_rd in the exit cycle, then T5/T6 as mul.
REQ-021 brzr/brnz/brpl/brmi: T3 Gra+R_out+CONin; T4 PC_out+Y_rd; T5 C_out+op_sel=ADD+Zlo_rd; T6 Zlo_out+PC_rd only if CON_output=1, sampled in T6.
REQ-022 jr: T3 Gra+R_out+PC_rd. jal: T3 PC_out+Grb... r15 written via Grb+Rin with IR[22:19] forced by encoder; T4 Gra+R_out+PC_rd.
REQ-023 in: T3 In_out+Gra+Rin. out: T3 Gra+R_out+Out_rd. mfhi/mflo: T3 HI_out/LO_out+Gra+Rin.
REQ-024 nop returns to T0 after T3; halt enters HALT after T3; run_req=0 sampled in T2 enters HALT after the current instruction.
REQ-025 op_sel is 0 whenever no ALU operation is being registered.

Reset
REQ-026 clr=0 asynchronously forces HALT, all outputs 0, fault 0; reset during any state (including DIV_WAIT) abandons the instruction.

Configuration
REQ-027 CU_DIV_TIMEOUT_EN defined: a counter bounds DIV_WAIT to DIV_TIMEOUT cycles; on expiry set fault=1 (sticky until reset) and enter HALT without writing Z/HI/LO.
REQ-028 CU_DIV_TIMEOUT_EN undefined: DIV_WAIT waits indefinitely; fault tied to 0; no counter logic.

Structure
REQ-029 Shared package cu_pkg holds opcode constants, op_sel encodings, and state enum.
REQ-030 Single sub-module cu_decode: combinational state+opcode to strobe vector; control_unit holds state register and counter.

Verification
REQ-031 clr released, run_req=1, IR=add r3,r1,r2 -> strobes per REQ-013/015 on cycles 1–6, back to T0 on cycle 7.
REQ-032 brzr with CON_output=0 -> PC_rd never asserted; with CON_output=1 -> PC_rd high exactly in T6.
REQ-033 div, calc_finished after 33 cycles -> reset_div 1 cycle, Zhi_rd+Zlo_rd once, LO_rd then HI_rd.
REQ-034 With CU_DIV_TIMEOUT_EN, calc_finished held 0 -> fault=1 and running=0 after 40 wait cycles.
REQ-035 clr=0 asserted mid-T5 of ld -> all strobes 0 immediately, state HALT, no Rin.
REQ-036 halt opcode then run_req toggled 0->1 -> fetch restarts at T0 next cycle.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: opcode table, ALU operation
// select encodings, FSM state enum, strobe bundle and opcode helpers.
package cu_pkg;

    typedef logic [4:0] opcode_t;

    // Opcode table, IR[31:27]. Encodings not listed here execute as nop.
    localparam opcode_t OpLd   = 5'd0;
    localparam opcode_t OpLdi  = 5'd1;
    localparam opcode_t OpSt   = 5'd2;
    localparam opcode_t OpAdd  = 5'd3;
    localparam opcode_t OpSub  = 5'd4;
    localparam opcode_t OpAnd  = 5'd5;
    localparam opcode_t OpOr   = 5'd6;
    localparam opcode_t OpRor  = 5'd7;
    localparam opcode_t OpRol  = 5'd8;
    localparam opcode_t OpShr  = 5'd9;
    localparam opcode_t OpShl  = 5'd11;
    localparam opcode_t OpAddi = 5'd12;
    localparam opcode_t OpAndi = 5'd13;
    localparam opcode_t OpOri  = 5'd14;
    localparam opcode_t OpDiv  = 5'd15;
    localparam opcode_t OpMul  = 5'd16;
    localparam opcode_t OpBr   = 5'd19;
    localparam opcode_t OpJr   = 5'd20;
    localparam opcode_t OpJal  = 5'd21;
    localparam opcode_t OpIn   = 5'd22;
    localparam opcode_t OpOut  = 5'd23;
    localparam opcode_t OpMflo = 5'd24;
    localparam opcode_t OpMfhi = 5'd25;
    localparam opcode_t OpNop  = 5'd26;
    localparam opcode_t OpHalt = 5'd27;

    // ALU operation select; zero means no operation is being registered.
    localparam logic [4:0] AluNone = 5'd0;
    localparam logic [4:0] AluAdd  = 5'd1;
    localparam logic [4:0] AluSub  = 5'd2;
    localparam logic [4:0] AluAnd  = 5'd3;
    localparam logic [4:0] AluOr   = 5'd4;
    localparam logic [4:0] AluShl  = 5'd5;
    localparam logic [4:0] AluShr  = 5'd6;
    localparam logic [4:0] AluRol  = 5'd7;
    localparam logic [4:0] AluRor  = 5'd8;
    localparam logic [4:0] AluMul  = 5'd9;
    localparam logic [4:0] AluDiv  = 5'd10;

    typedef enum logic [3:0] {
        StHalt, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StDivWait
    } state_t;

    typedef struct packed {
        logic pc_out, mar_rd, inc_pc, read, mdr_rd, mdr_out, ir_rd, y_rd;
        logic zlo_rd, zhi_rd, zlo_out, zhi_out, hi_rd, lo_rd, hi_out, lo_out;
        logic pc_rd, write, con_in, gra, grb, grc, r_in, r_out;
        logic ba_out, c_out, in_out, out_rd, reset_div;
        logic [4:0] op_sel;
    } strobes_t;

    // Final execute state of each instruction; after it the FSM refetches or halts.
    function automatic state_t last_state(input opcode_t op);
        case (op)
            OpAdd, OpSub, OpAnd, OpOr, OpShl, OpShr, OpRol, OpRor,
            OpAddi, OpAndi, OpOri, OpLdi:  return StT5;
            OpLd, OpSt:                    return StT7;
            OpMul, OpDiv, OpBr:            return StT6;
            OpJal:                         return StT4;
            OpNop, OpHalt:                 return StT3;
            default:                       return StT3;
        endcase
    endfunction

    // ALU select for the register and immediate arithmetic/logic group.
    function automatic logic [4:0] alu_sel(input opcode_t op);
        case (op)
            OpAdd, OpAddi: return AluAdd;
            OpSub:         return AluSub;
            OpAnd, OpAndi: return AluAnd;
            OpOr, OpOri:   return AluOr;
            OpShl:         return AluShl;
            OpShr:         return AluShr;
            OpRol:         return AluRol;
            OpRor:         return AluRor;
            default:       return AluNone;
        endcase
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational strobe decode for the control unit.
// Ports:
//   state         current FSM state
//   opcode        IR[31:27]
//   con_output    branch condition, only consulted in T6 of a branch
//   calc_finished divider done, marks the exit cycle of DIV_WAIT
//   strobes       full datapath strobe bundle including op_sel
module cu_decode
    import cu_pkg::*;
(
    input  state_t   state,
    input  opcode_t  opcode,
    input  logic     con_output,
    input  logic     calc_finished,
    output strobes_t strobes
);

    always_comb begin
        strobes = '0;
        case (state)
            StT0: begin strobes.pc_out = 1'b1; strobes.mar_rd = 1'b1; strobes.inc_pc = 1'b1; end
            StT1: begin strobes.read = 1'b1; strobes.mdr_rd = 1'b1; end
            StT2: begin strobes.mdr_out = 1'b1; strobes.ir_rd = 1'b1; end
            StT3: begin
                case (opcode)
                    OpAdd, OpSub, OpAnd, OpOr, OpShl, OpShr, OpRol, OpRor,
                    OpAddi, OpAndi, OpOri: begin
                        strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.y_rd = 1'b1;
                    end
                    OpLd, OpLdi, OpSt: begin
                        strobes.grb = 1'b1; strobes.ba_out = 1'b1; strobes.y_rd = 1'b1;
                    end
                    OpMul, OpDiv: begin
                        strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.y_rd = 1'b1;
                    end
                    OpBr: begin strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.con_in = 1'b1; end
                    OpJr: begin strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.pc_rd = 1'b1; end
                    // r15 link write; the register encoder forces the Grb field for jal
                    OpJal: begin strobes.pc_out = 1'b1; strobes.grb = 1'b1; strobes.r_in = 1'b1; end
                    OpIn:  begin strobes.in_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1; end
                    OpOut: begin strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.out_rd = 1'b1; end
                    OpMfhi: begin strobes.hi_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1; end
                    OpMflo: begin strobes.lo_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1; end
                    default: ;
                endcase
            end
            StT4: begin
                case (opcode)
                    OpAdd, OpSub, OpAnd, OpOr, OpShl, OpShr, OpRol, OpRor: begin
                        strobes.grc = 1'b1; strobes.r_out = 1'b1;
                        strobes.op_sel = alu_sel(opcode); strobes.zlo_rd = 1'b1;
                    end
                    OpAddi, OpAndi, OpOri: begin
                        strobes.c_out = 1'b1; strobes.op_sel = alu_sel(opcode); strobes.zlo_rd = 1'b1;
                    end
                    OpLd, OpLdi, OpSt: begin
                        strobes.c_out = 1'b1; strobes.op_sel = AluAdd; strobes.zlo_rd = 1'b1;
                    end
                    OpMul: begin
                        strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.op_sel = AluMul;
                        strobes.zhi_rd = 1'b1; strobes.zlo_rd = 1'b1;
                    end
                    OpDiv: begin
                        strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.op_sel = AluDiv;
                        strobes.reset_div = 1'b1;
                    end
                    OpBr:  begin strobes.pc_out = 1'b1; strobes.y_rd = 1'b1; end
                    OpJal: begin strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.pc_rd = 1'b1; end
                    default: ;
                endcase
            end
            StDivWait: begin
                strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.op_sel = AluDiv;
                // Z captures the quotient/remainder only in the cycle the divider reports done
                strobes.zhi_rd = calc_finished; strobes.zlo_rd = calc_finished;
            end
            StT5: begin
                case (opcode)
                    OpAdd, OpSub, OpAnd, OpOr, OpShl, OpShr, OpRol, OpRor,
                    OpAddi, OpAndi, OpOri, OpLdi: begin
                        strobes.zlo_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1;
                    end
                    OpLd, OpSt:   begin strobes.zlo_out = 1'b1; strobes.mar_rd = 1'b1; end
                    OpMul, OpDiv: begin strobes.zlo_out = 1'b1; strobes.lo_rd = 1'b1; end
                    OpBr: begin strobes.c_out = 1'b1; strobes.op_sel = AluAdd; strobes.zlo_rd = 1'b1; end
                    default: ;
                endcase
            end
            StT6: begin
                case (opcode)
                    OpLd:         begin strobes.read = 1'b1; strobes.mdr_rd = 1'b1; end
                    OpSt:         begin strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.mdr_rd = 1'b1; end
                    OpMul, OpDiv: begin strobes.zhi_out = 1'b1; strobes.hi_rd = 1'b1; end
                    OpBr:         begin strobes.zlo_out = con_output; strobes.pc_rd = con_output; end
                    default: ;
                endcase
            end
            StT7: begin
                case (opcode)
                    OpLd: begin strobes.mdr_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1; end
                    OpSt: strobes.write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Control unit for the single-bus CPU datapath: HALT/fetch/execute Moore FSM.
// Ports: clk, clr (async active-low reset), run_req, IR, CON_output, calc_finished in;
//   datapath strobes, op_sel, running, fault out.
// Optional feature: define CU_DIV_TIMEOUT_EN to bound DIV_WAIT to DIV_TIMEOUT cycles;
//   on expiry fault is set (sticky until clr) and the FSM halts without writing Z/HI/LO.
module control_unit
    import cu_pkg::*;
#(
    parameter int unsigned DIV_TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run_req,
    input  logic [31:0] IR,
    input  logic        CON_output,
    input  logic        calc_finished,
    output logic        PC_out, MAR_rd, IncPC, Read, MDR_rd, MDR_out, IR_rd, Y_rd,
    output logic        Zlo_rd, Zhi_rd, Zlo_out, Zhi_out, HI_rd, LO_rd, HI_out, LO_out,
    output logic        PC_rd, Write, CONin, Gra, Grb, Grc, Rin, R_out,
    output logic        BAout, C_out, In_out, Out_rd, reset_div,
    output logic [4:0]  op_sel,
    output logic        running,
    output logic        fault
);

    state_t   state_q, state_d;
    logic     stop_q, stop_d;
    logic     div_expired;
    opcode_t  opcode;
    state_t   instr_last;
    strobes_t strobes;

    assign opcode     = IR[31:27];
    assign instr_last = last_state(opcode);

    logic unused_ir;
    assign unused_ir = ^IR[26:0];

`ifdef CU_DIV_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(DIV_TIMEOUT + 1);

    logic [CntW-1:0] div_cnt_q;
    logic            fault_q;

    // Counter holds the number of DIV_WAIT cycles already spent before this one.
    assign div_expired = (div_cnt_q == CntW'(DIV_TIMEOUT - 1));
    assign fault       = fault_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            div_cnt_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            div_cnt_q <= (state_q == StDivWait) ? div_cnt_q + 1'b1 : '0;
            if (state_q == StDivWait && !calc_finished && div_expired) begin
                fault_q <= 1'b1;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg  = (DIV_TIMEOUT == 0);
    assign div_expired = 1'b0;
    assign fault       = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StHalt;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stop_d  = stop_q;
        case (state_q)
            StHalt: if (run_req) state_d = StT0;
            StT0:   state_d = StT1;
            StT1:   state_d = StT2;
            StT2: begin
                state_d = StT3;
                // A dropped run request lets the current instruction finish, then halts
                stop_d  = ~run_req;
            end
            StDivWait: begin
                if (calc_finished)    state_d = StT5;
                else if (div_expired) state_d = StHalt;
            end
            default: begin
                if (state_q == instr_last) begin
                    state_d = (opcode == OpHalt || stop_q) ? StHalt : StT0;
                end else if (state_q == StT4 && opcode == OpDiv) begin
                    state_d = StDivWait;
                end else begin
                    case (state_q)
                        StT3:    state_d = StT4;
                        StT4:    state_d = StT5;
                        StT5:    state_d = StT6;
                        StT6:    state_d = StT7;
                        default: state_d = StT0;
                    endcase
                end
            end
        endcase
    end

    cu_decode u_decode (
        .state         (state_q),
        .opcode        (opcode),
        .con_output    (CON_output),
        .calc_finished (calc_finished),
        .strobes       (strobes)
    );

    assign running   = (state_q != StHalt);
    assign PC_out    = strobes.pc_out;
    assign MAR_rd    = strobes.mar_rd;
    assign IncPC     = strobes.inc_pc;
    assign Read      = strobes.read;
    assign MDR_rd    = strobes.mdr_rd;
    assign MDR_out   = strobes.mdr_out;
    assign IR_rd     = strobes.ir_rd;
    assign Y_rd      = strobes.y_rd;
    assign Zlo_rd    = strobes.zlo_rd;
    assign Zhi_rd    = strobes.zhi_rd;
    assign Zlo_out   = strobes.zlo_out;
    assign Zhi_out   = strobes.zhi_out;
    assign HI_rd     = strobes.hi_rd;
    assign LO_rd     = strobes.lo_rd;
    assign HI_out    = strobes.hi_out;
    assign LO_out    = strobes.lo_out;
    assign PC_rd     = strobes.pc_rd;
    assign Write     = strobes.write;
    assign CONin     = strobes.con_in;
    assign Gra       = strobes.gra;
    assign Grb       = strobes.grb;
    assign Grc       = strobes.grc;
    assign Rin       = strobes.r_in;
    assign R_out     = strobes.r_out;
    assign BAout     = strobes.ba_out;
    assign C_out     = strobes.c_out;
    assign In_out    = strobes.in_out;
    assign Out_rd    = strobes.out_rd;
    assign reset_div = strobes.reset_div;
    assign op_sel    = strobes.op_sel;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
    import cu_pkg::*;

    localparam int TIMEOUT = 40;

    logic clk = 1'b0;
    logic clr, run_req, CON_output, calc_finished;
    logic [31:0] IR;
    logic PC_out, MAR_rd, IncPC, Read, MDR_rd, MDR_out, IR_rd, Y_rd;
    logic Zlo_rd, Zhi_rd, Zlo_out, Zhi_out, HI_rd, LO_rd, HI_out, LO_out;
    logic PC_rd, Write, CONin, Gra, Grb, Grc, Rin, R_out;
    logic BAout, C_out, In_out, Out_rd, reset_div;
    logic [4:0] op_sel;
    logic running, fault;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .clr(clr), .run_req(run_req), .IR(IR), .CON_output(CON_output),
        .calc_finished(calc_finished),
        .PC_out(PC_out), .MAR_rd(MAR_rd), .IncPC(IncPC), .Read(Read), .MDR_rd(MDR_rd),
        .MDR_out(MDR_out), .IR_rd(IR_rd), .Y_rd(Y_rd), .Zlo_rd(Zlo_rd), .Zhi_rd(Zhi_rd),
        .Zlo_out(Zlo_out), .Zhi_out(Zhi_out), .HI_rd(HI_rd), .LO_rd(LO_rd), .HI_out(HI_out),
        .LO_out(LO_out), .PC_rd(PC_rd), .Write(Write), .CONin(CONin), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .Rin(Rin), .R_out(R_out), .BAout(BAout), .C_out(C_out), .In_out(In_out),
        .Out_rd(Out_rd), .reset_div(reset_div), .op_sel(op_sel), .running(running),
        .fault(fault)
    );

    strobes_t got;
    always_comb begin
        got = '0;
        got.pc_out = PC_out;   got.mar_rd = MAR_rd;   got.inc_pc = IncPC;   got.read = Read;
        got.mdr_rd = MDR_rd;   got.mdr_out = MDR_out; got.ir_rd = IR_rd;    got.y_rd = Y_rd;
        got.zlo_rd = Zlo_rd;   got.zhi_rd = Zhi_rd;   got.zlo_out = Zlo_out; got.zhi_out = Zhi_out;
        got.hi_rd = HI_rd;     got.lo_rd = LO_rd;     got.hi_out = HI_out;  got.lo_out = LO_out;
        got.pc_rd = PC_rd;     got.write = Write;     got.con_in = CONin;   got.gra = Gra;
        got.grb = Grb;         got.grc = Grc;         got.r_in = Rin;       got.r_out = R_out;
        got.ba_out = BAout;    got.c_out = C_out;     got.in_out = In_out;  got.out_rd = Out_rd;
        got.reset_div = reset_div; got.op_sel = op_sel;
    end

    // Instruction classes of the reference model.
    localparam int CReg = 0, CImm = 1, CLd = 2, CLdi = 3, CSt = 4, CMul = 5, CDiv = 6;
    localparam int CBr = 7, CJr = 8, CJal = 9, CIn = 10, COut = 11, CMfhi = 12, CMflo = 13;
    localparam int CNop = 14, CHalt = 15;

    function automatic int cls_of(input logic [4:0] op);
        case (op)
            OpAdd, OpSub, OpAnd, OpOr, OpShl, OpShr, OpRol, OpRor: return CReg;
            OpAddi, OpAndi, OpOri: return CImm;
            OpLd: return CLd;   OpLdi: return CLdi;  OpSt: return CSt;
            OpMul: return CMul; OpDiv: return CDiv;  OpBr: return CBr;
            OpJr: return CJr;   OpJal: return CJal;  OpIn: return CIn;
            OpOut: return COut; OpMfhi: return CMfhi; OpMflo: return CMflo;
            OpHalt: return CHalt;
            default: return CNop;
        endcase
    endfunction

    function automatic logic [4:0] exp_alu(input logic [4:0] op);
        case (op)
            OpAdd, OpAddi: return AluAdd;
            OpSub: return AluSub;
            OpAnd, OpAndi: return AluAnd;
            OpOr, OpOri: return AluOr;
            OpShl: return AluShl;
            OpShr: return AluShr;
            OpRol: return AluRol;
            default: return AluRor;
        endcase
    endfunction

    strobes_t exp_q[$];
    int       exit_idx;

    // Expected per-cycle strobes of one instruction starting at fetch.
    // lat = number of divider wait cycles; lat = 0 means the divider never finishes.
    task automatic model_instr(input logic [4:0] op, input logic con, input int lat);
        strobes_t s;
        int c;
        c = cls_of(op);
        exp_q.delete();
        exit_idx = -1;
        s = '0; s.pc_out = 1; s.mar_rd = 1; s.inc_pc = 1; exp_q.push_back(s);
        s = '0; s.read = 1; s.mdr_rd = 1; exp_q.push_back(s);
        s = '0; s.mdr_out = 1; s.ir_rd = 1; exp_q.push_back(s);
        case (c)
            CReg, CImm: begin
                s = '0; s.grb = 1; s.r_out = 1; s.y_rd = 1; exp_q.push_back(s);
                s = '0; s.op_sel = exp_alu(op); s.zlo_rd = 1;
                if (c == CReg) begin s.grc = 1; s.r_out = 1; end else s.c_out = 1;
                exp_q.push_back(s);
                s = '0; s.zlo_out = 1; s.gra = 1; s.r_in = 1; exp_q.push_back(s);
            end
            CLd, CLdi, CSt: begin
                s = '0; s.grb = 1; s.ba_out = 1; s.y_rd = 1; exp_q.push_back(s);
                s = '0; s.c_out = 1; s.op_sel = AluAdd; s.zlo_rd = 1; exp_q.push_back(s);
                s = '0; s.zlo_out = 1;
                if (c == CLdi) begin s.gra = 1; s.r_in = 1; end else s.mar_rd = 1;
                exp_q.push_back(s);
                if (c == CLd) begin
                    s = '0; s.read = 1; s.mdr_rd = 1; exp_q.push_back(s);
                    s = '0; s.mdr_out = 1; s.gra = 1; s.r_in = 1; exp_q.push_back(s);
                end else if (c == CSt) begin
                    s = '0; s.gra = 1; s.r_out = 1; s.mdr_rd = 1; exp_q.push_back(s);
                    s = '0; s.write = 1; exp_q.push_back(s);
                end
            end
            CMul, CDiv: begin
                s = '0; s.gra = 1; s.r_out = 1; s.y_rd = 1; exp_q.push_back(s);
                s = '0; s.grb = 1; s.r_out = 1;
                if (c == CMul) begin
                    s.op_sel = AluMul; s.zhi_rd = 1; s.zlo_rd = 1; exp_q.push_back(s);
                end else begin
                    s.op_sel = AluDiv; s.reset_div = 1; exp_q.push_back(s);
                    for (int w = 1; w <= ((lat == 0) ? TIMEOUT : lat); w++) begin
                        s = '0; s.grb = 1; s.r_out = 1; s.op_sel = AluDiv;
                        if (w == lat) begin
                            s.zhi_rd = 1; s.zlo_rd = 1; exit_idx = exp_q.size();
                        end
                        exp_q.push_back(s);
                    end
                end
                if (!(c == CDiv && lat == 0)) begin
                    s = '0; s.zlo_out = 1; s.lo_rd = 1; exp_q.push_back(s);
                    s = '0; s.zhi_out = 1; s.hi_rd = 1; exp_q.push_back(s);
                end
            end
            CBr: begin
                s = '0; s.gra = 1; s.r_out = 1; s.con_in = 1; exp_q.push_back(s);
                s = '0; s.pc_out = 1; s.y_rd = 1; exp_q.push_back(s);
                s = '0; s.c_out = 1; s.op_sel = AluAdd; s.zlo_rd = 1; exp_q.push_back(s);
                s = '0; s.zlo_out = con; s.pc_rd = con; exp_q.push_back(s);
            end
            CJr:   begin s = '0; s.gra = 1; s.r_out = 1; s.pc_rd = 1; exp_q.push_back(s); end
            CJal: begin
                s = '0; s.pc_out = 1; s.grb = 1; s.r_in = 1; exp_q.push_back(s);
                s = '0; s.gra = 1; s.r_out = 1; s.pc_rd = 1; exp_q.push_back(s);
            end
            CIn:   begin s = '0; s.in_out = 1; s.gra = 1; s.r_in = 1; exp_q.push_back(s); end
            COut:  begin s = '0; s.gra = 1; s.r_out = 1; s.out_rd = 1; exp_q.push_back(s); end
            CMfhi: begin s = '0; s.hi_out = 1; s.gra = 1; s.r_in = 1; exp_q.push_back(s); end
            CMflo: begin s = '0; s.lo_out = 1; s.gra = 1; s.r_in = 1; exp_q.push_back(s); end
            default: begin s = '0; exp_q.push_back(s); end
        endcase
    endtask

    // Runs one instruction from T0, comparing every cycle; entered at posedge+1.
    // abort_at >= 0 pulls clr low in that cycle and checks the immediate reset.
    task automatic exec_instr(input logic [4:0] op, input logic con, input int lat,
                              input logic stop, input int abort_at, input string name,
                              output logic halted);
        logic [31:0] rnd;
        rnd = $urandom;
        model_instr(op, con, lat);
        IR = {op, rnd[26:0]};
        run_req = ~stop;
        CON_output = con;
        halted = (cls_of(op) == CHalt) || stop || (cls_of(op) == CDiv && lat == 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            calc_finished = (i == exit_idx);
            if (i == abort_at) begin
                clr = 1'b0;
                #1;
                checks++;
                if (got !== '0 || running !== 1'b0 || fault !== 1'b0)
                    $display("FAIL %s async_reset: got strobes=%h running=%b fault=%b, want 0/0/0",
                             name, got, running, fault);
                if (got !== '0 || running !== 1'b0 || fault !== 1'b0) failures++;
                calc_finished = 1'b0;
                return;
            end
            @(negedge clk);
            checks++;
            if (got !== exp_q[i] || running !== 1'b1 || fault !== 1'b0) begin
                failures++;
                $display("FAIL %s cyc=%0d: got strobes=%h running=%b fault=%b, want %h running=1 fault=0",
                         name, i, got, running, fault, exp_q[i]);
            end
            @(posedge clk); #1;
        end
        calc_finished = 1'b0;
    endtask

    task automatic halt_cycle(input logic rr, input logic exp_fault, input string name);
        run_req = rr;
        @(negedge clk);
        checks++;
        if (got !== '0 || running !== 1'b0 || fault !== exp_fault) begin
            failures++;
            $display("FAIL %s halt: got strobes=%h running=%b fault=%b, want 0 running=0 fault=%b",
                     name, got, running, fault, exp_fault);
        end
        @(posedge clk); #1;
    endtask

    // Checks the fetch-T0 strobes at posedge+2 without consuming the cycle.
    task automatic check_at_t0(input string name);
        strobes_t s;
        s = '0; s.pc_out = 1; s.mar_rd = 1; s.inc_pc = 1;
        #1;
        checks++;
        if (got !== s || running !== 1'b1) begin
            failures++;
            $display("FAIL %s t0: got strobes=%h running=%b, want %h running=1",
                     name, got, running, s);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; run_req = 1'b1; IR = '0; CON_output = 1'b0; calc_finished = 1'b0;
        #3 clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (got !== '0 || running !== 1'b0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL reset: got strobes=%h running=%b fault=%b, want 0/0/0",
                     got, running, fault);
        end
        clr = 1'b1;
        halt_cycle(1'b1, 1'b0, "release");
    endtask

    task automatic test_add();
        logic h;
        exec_instr(OpAdd, 1'b0, 1, 1'b0, -1, "add_r3_r1_r2", h);
        check_at_t0("add_refetch");
    endtask

    task automatic test_branch();
        logic h;
        exec_instr(OpBr, 1'b0, 1, 1'b0, -1, "brzr_con0", h);
        exec_instr(OpBr, 1'b1, 1, 1'b0, -1, "brzr_con1", h);
    endtask

    task automatic test_div();
        logic h;
        exec_instr(OpDiv, 1'b0, 33, 1'b0, -1, "div_lat33", h);
        exec_instr(OpDiv, 1'b0, 1, 1'b0, -1, "div_lat1", h);
        exec_instr(OpMul, 1'b0, 1, 1'b0, -1, "mul", h);
    endtask

    task automatic test_reset_mid_ld();
        logic h;
        exec_instr(OpLd, 1'b0, 1, 1'b0, 5, "ld_abort_t5", h);
        @(posedge clk); #1;
        checks++;
        if (got !== '0 || running !== 1'b0) begin
            failures++;
            $display("FAIL ld_abort_held: got strobes=%h running=%b, want 0/0", got, running);
        end
        clr = 1'b1;
        halt_cycle(1'b1, 1'b0, "ld_abort_release");
    endtask

    task automatic test_halt_restart();
        logic h;
        exec_instr(OpHalt, 1'b0, 1, 1'b0, -1, "halt_op", h);
        halt_cycle(1'b0, 1'b0, "halt_idle0");
        halt_cycle(1'b0, 1'b0, "halt_idle1");
        halt_cycle(1'b1, 1'b0, "halt_wake");
        check_at_t0("halt_restart");
        exec_instr(OpSub, 1'b0, 1, 1'b1, -1, "sub_stop", h);
        halt_cycle(1'b0, 1'b0, "stop_idle");
        halt_cycle(1'b1, 1'b0, "stop_wake");
    endtask

    task automatic test_back_to_back();
        logic h;
        logic [4:0] op;
        for (int n = 0; n < 40; n++) begin
            op = 5'($urandom_range(0, 31));
            exec_instr(op, 1'($urandom_range(0, 1)), $urandom_range(1, 20),
                       ($urandom_range(0, 7) == 0), -1, "random", h);
            if (h) begin
                halt_cycle(1'b0, 1'b0, "random_idle");
                halt_cycle(1'b1, 1'b0, "random_wake");
            end
        end
    endtask

    task automatic test_div_timeout();
        logic h;
`ifdef CU_DIV_TIMEOUT_EN
        exec_instr(OpDiv, 1'b0, 0, 1'b0, -1, "div_timeout", h);
        halt_cycle(1'b0, 1'b1, "timeout_halt");
        halt_cycle(1'b0, 1'b1, "timeout_sticky");
        clr = 1'b0;
        #1;
        checks++;
        if (fault !== 1'b0 || running !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: got fault=%b running=%b, want 0/0", fault, running);
        end
        clr = 1'b1;
        halt_cycle(1'b1, 1'b0, "timeout_release");
`else
        // Without the timeout, a divide longer than the timeout value still completes.
        exec_instr(OpDiv, 1'b0, TIMEOUT + 5, 1'b0, -1, "div_no_timeout", h);
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_div();
        test_reset_mid_ld();
        test_halt_restart();
        test_back_to_back();
        test_div_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within 1000000 time units");
        $fatal(1);
    end

endmodule
